median_window_ctrl: RTL and testbench
=====================================

Name: median_window_ctrl

Overview:
- Streaming controller that sequences the 3x3 median datapath over a raster image.
- Accepts one pixel per cycle on a valid/ready input stream and keeps two line buffers plus a 3x3 window register.
- Drives the nine window taps to the external combinational median core and registers its result onto a valid/ready output stream.
- Emits one median per interior pixel, (IMG_W-2)x(IMG_H-2) per frame; border pixels produce no output.

Parameters:
- PIX_W, 8, pixel width in bits; must match the median core.
- IMG_W, 640, pixels per line; minimum 3.
- IMG_H, 480, lines per frame; minimum 3.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller can accept a pixel
- in_sof  in  1  qualifies an accepted pixel as the first of a frame, pixel (0,0)
- in_data  in  PIX_W  input pixel
- win_a..win_i  out  PIX_W each  window taps to the median core inputs A..I
- med_in  in  PIX_W  median core output (combinational on win_a..win_i)
- out_valid  out  1  median result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  PIX_W  registered median
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clk edge.
  - out_valid=0, out_data=0, frame_done=0, sof_err=0.
  - Window registers 0, column and row counters 0, state IDLE.
  - Line-buffer contents are don't-care and are not cleared.
  - in_ready=1 out of reset.
  - Reset mid-frame discards the frame; the next accepted in_sof starts a fresh frame.
- Accept: a pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single-entry output register).
- States:
  - IDLE: non-sof pixels are accepted and dropped. An accepted in_sof pixel is treated as (0,0) and moves to PRIME.
  - PRIME: rows 0-1, plus columns 0-1 of every row. Pixels are stored, nothing is emitted. Moves to RUN on the accept at x>=2, y>=2.
  - RUN: every accepted pixel at x>=2, y>=2 completes a window.
  - After the accept at (IMG_W-1, IMG_H-1): pulse frame_done and return to IDLE.
  - A row start (x returning to 0) stays in PRIME/RUN, since columns 0-1 never emit.
- Counters:
  - x wraps at IMG_W-1 to 0 and increments y.
  - y wraps at IMG_H-1 to 0.
  - Counter widths are $clog2 of IMG_W and of IMG_H.
- Line buffers:
  - LB0 holds row y-1 and LB1 holds row y-2, each IMG_W x PIX_W.
  - On accept at column x: read LB1[x] and LB0[x], then write LB1[x]<=LB0[x] and LB0[x]<=in_data.
  - Read-before-write at the same address within the cycle.
- Window: on accept, all three rows shift left by one column; new right column is {LB1[x], LB0[x], in_data}.
- Tap mapping (row-major, A oldest):
  - A,B,C = row y-2, columns x-2..x
  - D,E,F = row y-1, columns x-2..x
  - G,H,I = row y, columns x-2..x
  - Centre E = pixel (x-1, y-1).
- Output and latency:
  - The cycle after an accept that completes a window: out_valid=1 and out_data = med_in evaluated on the updated window.
  - Latency is 1 cycle from accepted input pixel to out_valid.
  - out_data is held stable while out_valid && !out_ready.
- Simultaneous events:
  - out_ready and a new completing accept in the same cycle: the register reloads and out_valid stays 1 with no bubble.
  - frame_done can coincide with out_valid for the last window.
- in_sof mid-frame (state PRIME or RUN, position not (0,0)):
  - Pulse sof_err.
  - Treat the pixel as (0,0) of a new frame and re-enter PRIME.
  - A pending out_valid result is still delivered.
- in_sof at position (0,0) while not in IDLE is legal, with no error.
- Backpressure never drops or duplicates a pixel.

Decomposition:
- Shared package median_pkg: PIX_W default, the pixel typedef, and the ctrl_state_t enum {IDLE, PRIME, RUN}.
- One natural sub-module: median_line_buf, a single-port read-before-write line memory of IMG_W x PIX_W, instantiated twice.
- The median core is instantiated by the parent, not inside this block.

Test Plan:
1. Reset: hold rst_n=0 for 2 clks with in_valid=1. Require out_valid=0, out_data=0, frame_done=0, sof_err=0, in_ready=1.
2. IMG_W=5, IMG_H=4, constant 0x40 frame, out_ready=1. Require exactly 6 outputs, all 0x40; first out_valid 1 clk after accepting pixel (2,2); frame_done pulses on accepting (4,3).
3. Ramp frame, pixel = 5y+x. Require outputs 6,7,8,11,12,13 in order, each equal to the window centre.
4. Backpressure: hold out_ready=0 for 5 clks after the first out_valid. Require in_ready=0, out_data stable at 6, no pixel lost; remaining outputs match scenario 3.
5. Impulse: zero frame with 0xFF at (2,1). Require all 6 outputs 0x00; win_e=0xFF on the window centred at (2,1).
6. Mid-frame sof: assert in_sof at (3,2) of frame 1, then stream a full constant-0x10 frame. Require sof_err one pulse and no frame_done for frame 1. Then 6 outputs of 0x10 and frame_done once.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types for the 3x3 median window controller.
package median_pkg;
  localparam int PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pix_t;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} ctrl_state_t;
endpackage

// File: rtl/median_window_ctrl_if.sv
// Pixel input stream and median output stream of the window controller.
interface median_window_ctrl_if #(parameter int PIX_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;

  modport master (output in_valid, in_sof, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_sof, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/median_line_buf.sv
// Single-port line memory: asynchronous read, write on clock, so a read and
// a write to the same address in one cycle return the old contents.
module median_line_buf #(
  parameter  int DEPTH = 640,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/median_window_ctrl.sv
// Raster sequencer for a 3x3 median: two line buffers, a 3x3 window and a
// single-entry output register fed by the external median core.
module median_window_ctrl import median_pkg::*; #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  median_window_ctrl_if.slave bus,
  output logic [PIX_W-1:0] o_win_a,
  output logic [PIX_W-1:0] o_win_b,
  output logic [PIX_W-1:0] o_win_c,
  output logic [PIX_W-1:0] o_win_d,
  output logic [PIX_W-1:0] o_win_e,
  output logic [PIX_W-1:0] o_win_f,
  output logic [PIX_W-1:0] o_win_g,
  output logic [PIX_W-1:0] o_win_h,
  output logic [PIX_W-1:0] o_win_i,
  input  logic [PIX_W-1:0] i_med_in,
  output logic             o_frame_done,
  output logic             o_sof_err
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  ctrl_state_t r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [8:0][PIX_W-1:0] r_win;
  logic [8:0][PIX_W-1:0] w_win;
  logic r_out_valid, r_frame_done, r_sof_err;
  logic [PIX_W-1:0] r_out_data;

  logic w_acc, w_store, w_done_win, w_x_end, w_last, w_sof_mid;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_frame_done  = r_frame_done;
  assign o_sof_err     = r_sof_err;

  // An accepted sof always lands at (0,0); outside a frame only sof is kept.
  assign w_acc      = bus.in_valid && bus.in_ready;
  assign w_store    = w_acc && (r_state != IDLE || bus.in_sof);
  assign w_px       = bus.in_sof ? '0 : r_x;
  assign w_py       = bus.in_sof ? '0 : r_y;
  assign w_x_end    = (w_px == X_LAST);
  assign w_last     = w_x_end && (w_py == Y_LAST);
  assign w_done_win = w_store && (w_px >= X_TWO) && (w_py >= Y_TWO);
  assign w_sof_mid  = w_acc && bus.in_sof && (r_state != IDLE) &&
                      (r_x != '0 || r_y != '0);

  median_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
    .i_clk(i_clk), .i_we(w_store), .i_addr(w_px),
    .i_wdata(bus.in_data), .o_rdata(w_lb0_rd));

  median_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .i_clk(i_clk), .i_we(w_store), .i_addr(w_px),
    .i_wdata(w_lb0_rd), .o_rdata(w_lb1_rd));

  // Taps show the window as it will be after this accept, so the median core
  // result can be registered on the same edge: one cycle input-to-output.
  always_comb begin
    w_win = r_win;
    if (w_store) begin
      w_win[0] = r_win[1]; w_win[1] = r_win[2]; w_win[2] = w_lb1_rd;
      w_win[3] = r_win[4]; w_win[4] = r_win[5]; w_win[5] = w_lb0_rd;
      w_win[6] = r_win[7]; w_win[7] = r_win[8]; w_win[8] = bus.in_data;
    end
  end

  assign o_win_a = w_win[0];
  assign o_win_b = w_win[1];
  assign o_win_c = w_win[2];
  assign o_win_d = w_win[3];
  assign o_win_e = w_win[4];
  assign o_win_f = w_win[5];
  assign o_win_g = w_win[6];
  assign o_win_h = w_win[7];
  assign o_win_i = w_win[8];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_win        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= w_store && w_last;
      r_sof_err    <= w_sof_mid;
      if (w_store) begin
        r_win <= w_win;
        r_x   <= w_x_end ? '0 : w_px + 1'b1;
        if (w_x_end) r_y <= (w_py == Y_LAST) ? '0 : w_py + 1'b1;
        else         r_y <= w_py;
        if (w_last)          r_state <= IDLE;
        else if (w_done_win) r_state <= RUN;
        else if (bus.in_sof) r_state <= PRIME;
      end
      // A completing accept implies in_ready, so the register is free or draining.
      if (w_done_win) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_med_in;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl on a 5x4 image with a behavioural median core.
module tb_median_window_ctrl;
  import median_pkg::*;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median_window_ctrl_if #(.PIX_W(8)) bus();
  pix_t win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i, med_in;
  logic frame_done, sof_err;

  median_window_ctrl #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_win_a(win_a), .o_win_b(win_b), .o_win_c(win_c),
    .o_win_d(win_d), .o_win_e(win_e), .o_win_f(win_f),
    .o_win_g(win_g), .o_win_h(win_h), .o_win_i(win_i),
    .i_med_in(med_in), .o_frame_done(frame_done), .o_sof_err(sof_err));

  function automatic pix_t median9(input pix_t v[9]);
    pix_t t;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  always_comb begin
    pix_t t[9];
    t[0] = win_a; t[1] = win_b; t[2] = win_c;
    t[3] = win_d; t[4] = win_e; t[5] = win_f;
    t[6] = win_g; t[7] = win_h; t[8] = win_i;
    med_in = median9(t);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  pix_t outq[$];
  int fd_cnt, se_cnt, fd_cyc, first_ov_cyc;
  pix_t last_tap_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (sof_err) se_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic pix_t pix(input int kind, input int x, input int y);
    case (kind)
      0: return 8'h40;
      1: return pix_t'(5 * y + x);
      2: return (x == 2 && y == 1) ? 8'hFF : 8'h00;
      default: return 8'h10;
    endcase
  endfunction

  task automatic clear_mon();
    outq.delete();
    fd_cnt = 0; se_cnt = 0; fd_cyc = -1; first_ov_cyc = -1;
  endtask

  // Presents one pixel from posedge+1 until it is taken; returns the accept edge count.
  task automatic send(input pix_t d, input logic s, output int acc);
    logic rdy;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = s; acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (rdy) last_tap_e = win_e;
      @(posedge clk); #1;
      if (rdy) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready stuck low, required accept of %0h", d);
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input int kind, output int acc22, output int acc_last);
    int a;
    acc22 = -1; acc_last = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send(pix(kind, x, y), (x == 0 && y == 0), a);
        if (x == 2 && y == 2) acc22 = a;
        if (x == W-1 && y == H-1) acc_last = a;
      end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_outs(input string name, input pix_t exp[$]);
    checks++;
    if (outq.size() !== exp.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, outq.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (outq[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s_out[%0d] got=%0h exp=%0h", name, i, outq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_data = 8'h55; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (sof_err !== 1'b0) begin failures++; $display("FAIL reset_sof_err got=%b exp=0", sof_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_const();
    int a, a22, al;
    pix_t exp[$];
    clear_mon();
    send(8'h99, 1'b0, a);  // dropped while idle
    send_frame(0, a22, al);
    drain();
    exp = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    check_outs("const", exp);
    checks++; if (first_ov_cyc !== a22) begin failures++; $display("FAIL const_latency got=%0d exp=%0d", first_ov_cyc, a22); end
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL const_frame_done_cnt got=%0d exp=1", fd_cnt); end
    checks++; if (fd_cyc !== al) begin failures++; $display("FAIL const_frame_done_cyc got=%0d exp=%0d", fd_cyc, al); end
    checks++; if (se_cnt !== 0) begin failures++; $display("FAIL const_sof_err got=%0d exp=0", se_cnt); end
  endtask

  task automatic test_ramp();
    int a22, al;
    pix_t exp[$];
    clear_mon();
    send_frame(1, a22, al);
    drain();
    exp = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
    check_outs("ramp", exp);
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL ramp_frame_done_cnt got=%0d exp=1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    int a22, al;
    logic seen;
    pix_t exp[$];
    clear_mon();
    seen = 1'b0;
    fork
      send_frame(1, a22, al);
      begin
        for (int n = 0; n < 200; n++) begin
          if (bus.out_valid) begin seen = 1'b1; break; end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, bus.in_ready); end
          checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, bus.out_valid); end
          checks++; if (bus.out_data !== 8'd6) begin failures++; $display("FAIL bp_out_data[%0d] got=%0h exp=6", k, bus.out_data); end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", seen); end
    exp = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
    check_outs("bp", exp);
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL bp_frame_done_cnt got=%0d exp=1", fd_cnt); end
  endtask

  task automatic test_impulse();
    int a;
    pix_t exp[$];
    clear_mon();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send(pix(2, x, y), (x == 0 && y == 0), a);
        if (x == 3 && y == 2) begin
          checks++;
          if (last_tap_e !== 8'hFF) begin failures++; $display("FAIL impulse_win_e got=%0h exp=ff", last_tap_e); end
        end
      end
    drain();
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_outs("impulse", exp);
  endtask

  task automatic test_mid_sof();
    int a, al;
    pix_t exp[$];
    clear_mon();
    for (int i = 0; i < 2 * W + 3; i++)
      send(pix(1, i % W, i / W), (i == 0), a);
    send(8'h10, 1'b1, a);  // arrives at (3,2) of the ramp frame
    for (int i = 1; i < W * H; i++) send(8'h10, 1'b0, al);
    drain();
    checks++; if (se_cnt !== 1) begin failures++; $display("FAIL midsof_sof_err_cnt got=%0d exp=1", se_cnt); end
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL midsof_frame_done_cnt got=%0d exp=1", fd_cnt); end
    checks++; if (fd_cyc !== al) begin failures++; $display("FAIL midsof_frame_done_cyc got=%0d exp=%0d", fd_cyc, al); end
    exp = '{8'd6, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    check_outs("midsof", exp);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    clear_mon();
    last_tap_e = '0;
    test_reset();
    test_const();
    test_ramp();
    test_backpressure();
    test_impulse();
    test_mid_sof();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
